// File: rtl/washer_seq.sv
// Washing-machine phase sequencer: fill, agitate (fwd/pause/rev/pause), drain, spin.
// Define WASHER_SEQ_LEVEL_EN to add the level_full sensor and the FILL timeout fault.
module washer_seq #(
    parameter int unsigned T_W     = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned T_FILL  = 60,
    parameter int unsigned T_AGIT  = 60,
    parameter int unsigned T_PAUSE = 5,
    parameter int unsigned T_DRAIN = 60,
    parameter int unsigned T_SPIN  = 60,
    parameter int unsigned N_WASH  = 7,
    parameter int unsigned N_RINSE = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_sel,
    input  logic             start,
    input  logic             estop,
    input  logic             pause,
`ifdef WASHER_SEQ_LEVEL_EN
    input  logic             level_full,
`endif
    output logic             inlet,
    output logic             drain,
    output logic             dry,
    output logic             motor_fwd,
    output logic             motor_rev,
    output logic             idle_led,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] cycles_left,
    output logic [T_W-1:0]   sec_left
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FILL    = 4'd1,
        S_AGIT_F  = 4'd2,
        S_PAUSE_A = 4'd3,
        S_AGIT_R  = 4'd4,
        S_PAUSE_B = 4'd5,
        S_DRAIN   = 4'd6,
        S_SPIN    = 4'd7,
        S_DONE    = 4'd8,
        S_FAULT   = 4'd9
    } state_t;

    localparam logic [1:0] MODE_RINSE = 2'd1;
    localparam logic [1:0] MODE_FULL  = 2'd2;
    localparam logic [1:0] MODE_SPIN  = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             rinse_blk_q, rinse_blk_d;
    logic [T_W-1:0]   sec_q, sec_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic             busy_st;
    logic             timer_exp;
    logic             go;
    state_t           tgt;
    logic [CNT_W-1:0] cyc_load;

    // Timer reload value: the state lasts dur+1 cycles including the exit edge.
    function automatic logic [T_W-1:0] dur(input state_t s);
        case (s)
            S_FILL:               dur = T_W'(T_FILL - 1);
            S_AGIT_F, S_AGIT_R:   dur = T_W'(T_AGIT - 1);
            S_PAUSE_A, S_PAUSE_B: dur = T_W'(T_PAUSE - 1);
            S_DRAIN:              dur = T_W'(T_DRAIN - 1);
            S_SPIN:               dur = T_W'(T_SPIN - 1);
            default:              dur = '0;
        endcase
    endfunction

    assign busy_st  = (state_q >= S_FILL) && (state_q <= S_SPIN);
    assign cyc_load = rinse_blk_q ? CNT_W'(N_RINSE) : CNT_W'(N_WASH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            rinse_blk_q <= 1'b0;
            sec_q       <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rinse_blk_q <= rinse_blk_d;
            sec_q       <= sec_d;
            cyc_q       <= cyc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rinse_blk_d = rinse_blk_q;
        sec_d       = sec_q;
        cyc_d       = cyc_q;
        go          = 1'b0;
        tgt         = state_q;
        timer_exp   = (sec_q == '0);
        if (estop) begin
            state_d     = S_IDLE;
            mode_d      = 2'd0;
            rinse_blk_d = 1'b0;
            sec_d       = '0;
            cyc_d       = '0;
        end else if (!(pause && busy_st)) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && (mode_sel != 2'd0)) begin
                        mode_d      = mode_sel;
                        rinse_blk_d = (mode_sel == MODE_RINSE);
                        go          = 1'b1;
                        tgt         = (mode_sel == MODE_SPIN) ? S_DRAIN : S_FILL;
                    end
                end
                S_FILL: begin
`ifdef WASHER_SEQ_LEVEL_EN
                    if (level_full) begin
                        go    = 1'b1;
                        tgt   = S_AGIT_F;
                        cyc_d = cyc_load;
                    end else if (timer_exp) begin
                        go  = 1'b1;
                        tgt = S_FAULT;
                    end
`else
                    if (timer_exp) begin
                        go    = 1'b1;
                        tgt   = S_AGIT_F;
                        cyc_d = cyc_load;
                    end
`endif
                end
                S_AGIT_F:  if (timer_exp) begin go = 1'b1; tgt = S_PAUSE_A; end
                S_PAUSE_A: if (timer_exp) begin go = 1'b1; tgt = S_AGIT_R;  end
                S_AGIT_R:  if (timer_exp) begin go = 1'b1; tgt = S_PAUSE_B; end
                S_PAUSE_B: begin
                    if (timer_exp) begin
                        go = 1'b1;
                        if (cyc_q > CNT_W'(1)) begin
                            tgt   = S_AGIT_F;
                            cyc_d = cyc_q - CNT_W'(1);
                        end else begin
                            tgt   = S_DRAIN;
                            cyc_d = '0;
                        end
                    end
                end
                // A full wash drains twice: after the wash block and after the rinse block.
                S_DRAIN: begin
                    if (timer_exp) begin
                        go = 1'b1;
                        if ((mode_q == MODE_FULL) && !rinse_blk_q) begin
                            tgt         = S_FILL;
                            rinse_blk_d = 1'b1;
                        end else if (mode_q == MODE_RINSE) begin
                            tgt = S_DONE;
                        end else begin
                            tgt = S_SPIN;
                        end
                    end
                end
                S_SPIN:  if (timer_exp) begin go = 1'b1; tgt = S_DONE; end
                default: ;
            endcase
            if (go) begin
                state_d = tgt;
                sec_d   = dur(tgt);
            end else if (busy_st && !timer_exp) begin
                sec_d = sec_q - T_W'(1);
            end
        end
    end

    // Actuators are silenced while a run is held by pause.
    always_comb begin
        inlet     = (state_q == S_FILL) && !pause;
        motor_fwd = (state_q == S_AGIT_F) && !pause;
        motor_rev = (state_q == S_AGIT_R) && !pause;
        drain     = ((state_q == S_DRAIN) || (state_q == S_SPIN)) && !pause;
        dry       = (state_q == S_SPIN) && !pause;
        idle_led  = state_q inside {S_IDLE, S_PAUSE_A, S_PAUSE_B, S_DONE, S_FAULT};
        busy      = busy_st;
        done      = (state_q == S_DONE);
`ifdef WASHER_SEQ_LEVEL_EN
        fault     = (state_q == S_FAULT);
`else
        fault     = 1'b0;
`endif
    end

    assign phase       = state_q;
    assign cycles_left = cyc_q;
    assign sec_left    = sec_q;

endmodule

// File: tb/tb_washer_seq.sv
// Scoreboard bench for washer_seq: stimulus queues expected values per clock edge,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_washer_seq;
    localparam int T_W   = 8;
    localparam int CNT_W = 4;

    localparam int SG_PHASE = 0, SG_DONE = 1, SG_BUSY = 2, SG_IDLE = 3, SG_FWD = 4,
                   SG_DRAIN = 5, SG_INLET = 6, SG_CYC = 7, SG_SEC = 8, SG_FAULT = 9,
                   SG_DRY = 10, SG_REV = 11;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, start, estop, pause;
    logic [1:0]       mode_sel;
    logic             inlet, drain, dry, motor_fwd, motor_rev, idle_led, busy, done, fault;
    logic [3:0]       phase;
    logic [CNT_W-1:0] cycles_left;
    logic [T_W-1:0]   sec_left;
`ifdef WASHER_SEQ_LEVEL_EN
    logic level_full, auto_level, man_level;
    always_comb level_full = auto_level ? ((phase == 4'd1) && (sec_left == '0)) : man_level;
`endif

    exp_t sb[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    washer_seq #(
        .T_W(T_W), .CNT_W(CNT_W), .T_FILL(3), .T_AGIT(4), .T_PAUSE(2),
        .T_DRAIN(3), .T_SPIN(3), .N_WASH(2), .N_RINSE(1)
    ) dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .start(start), .estop(estop),
        .pause(pause),
`ifdef WASHER_SEQ_LEVEL_EN
        .level_full(level_full),
`endif
        .inlet(inlet), .drain(drain), .dry(dry), .motor_fwd(motor_fwd),
        .motor_rev(motor_rev), .idle_led(idle_led), .busy(busy), .done(done),
        .fault(fault), .phase(phase), .cycles_left(cycles_left), .sec_left(sec_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int sig_val(input int s);
        case (s)
            SG_PHASE: return int'(phase);
            SG_DONE:  return int'(done);
            SG_BUSY:  return int'(busy);
            SG_IDLE:  return int'(idle_led);
            SG_FWD:   return int'(motor_fwd);
            SG_DRAIN: return int'(drain);
            SG_INLET: return int'(inlet);
            SG_CYC:   return int'(cycles_left);
            SG_SEC:   return int'(sec_left);
            SG_FAULT: return int'(fault);
            SG_DRY:   return int'(dry);
            SG_REV:   return int'(motor_rev);
            default:  return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp_v, edge_n);
        end
    endtask

    // Monitor: compare every queued expectation whose edge has arrived.
    always @(negedge clk) begin
        int   i;
        exp_t e;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= edge_n) begin
                e = sb[i];
                sb.delete(i);
                chk(e.tag, sig_val(e.sig), e.val);
            end else begin
                i++;
            end
        end
        chk("excl_motor", int'(motor_fwd && motor_rev), 0);
        chk("excl_water", int'(inlet && drain), 0);
    end

    task automatic expect_at(input int cyc, input int sig, input int val, input string tag);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int c);
        while (edge_n < c) tick(1);
    endtask

    task automatic launch(input logic [1:0] m, output int e);
        mode_sel = m;
        start    = 1'b1;
        e        = edge_n + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1; start = 1'b0; estop = 1'b0; pause = 1'b0; mode_sel = 2'd0;
`ifdef WASHER_SEQ_LEVEL_EN
        auto_level = 1'b1; man_level = 1'b0;
`endif
        expect_at(2, SG_PHASE, 0, "rst_phase");
        expect_at(2, SG_IDLE, 1, "rst_idle_led");
        expect_at(2, SG_BUSY, 0, "rst_busy");
        expect_at(2, SG_DONE, 0, "rst_done");
        expect_at(2, SG_SEC, 0, "rst_sec");
        expect_at(2, SG_CYC, 0, "rst_cyc");
        expect_at(2, SG_INLET, 0, "rst_inlet");
        tick(2);
        rst = 1'b0;

        // start with mode 0 leaves IDLE
        launch(2'd0, e);
        expect_at(e, SG_PHASE, 0, "mode0_idle_phase");
        expect_at(e, SG_BUSY, 0, "mode0_idle_busy");
        tick(1); start = 1'b0;

        // rinse, with an ignored start while busy
        launch(2'd1, e);
        expect_at(e, SG_PHASE, 1, "rinse_fill");
        expect_at(e, SG_INLET, 1, "rinse_inlet");
        expect_at(e, SG_SEC, 2, "rinse_fill_sec");
        expect_at(e, SG_CYC, 0, "rinse_fill_cyc");
        expect_at(e + 3, SG_PHASE, 2, "rinse_agit_f");
        expect_at(e + 3, SG_FWD, 1, "rinse_fwd");
        expect_at(e + 3, SG_CYC, 1, "rinse_cyc");
        expect_at(e + 3, SG_SEC, 3, "rinse_agit_sec");
        expect_at(e + 6, SG_PHASE, 2, "busy_start_phase");
        expect_at(e + 6, SG_SEC, 0, "busy_start_sec");
        expect_at(e + 7, SG_PHASE, 3, "rinse_pause_a");
        expect_at(e + 7, SG_IDLE, 1, "rinse_pause_led");
        expect_at(e + 9, SG_PHASE, 4, "rinse_agit_r");
        expect_at(e + 9, SG_REV, 1, "rinse_rev");
        expect_at(e + 13, SG_PHASE, 5, "rinse_pause_b");
        expect_at(e + 15, SG_PHASE, 6, "rinse_drain");
        expect_at(e + 15, SG_DRAIN, 1, "rinse_drain_out");
        expect_at(e + 15, SG_CYC, 0, "rinse_drain_cyc");
        expect_at(e + 17, SG_DONE, 0, "rinse_not_done");
        expect_at(e + 18, SG_DONE, 1, "rinse_done");
        expect_at(e + 18, SG_BUSY, 0, "rinse_done_busy");
        expect_at(e + 20, SG_DONE, 1, "rinse_done_hold");
        tick(1); start = 1'b0;
        wait_to(e + 5);
        mode_sel = 2'd3; start = 1'b1;
        tick(1); start = 1'b0;
        wait_to(e + 20);

        // full wash started from DONE
        launch(2'd2, e);
        expect_at(e, SG_PHASE, 1, "full_fill1");
        expect_at(e, SG_DONE, 0, "full_done_clr");
        expect_at(e + 3, SG_CYC, 2, "full_cyc2");
        expect_at(e + 14, SG_PHASE, 5, "full_pause_b1");
        expect_at(e + 14, SG_CYC, 2, "full_cyc2_pb");
        expect_at(e + 15, SG_PHASE, 2, "full_agit2");
        expect_at(e + 15, SG_CYC, 1, "full_cyc1");
        expect_at(e + 27, SG_PHASE, 6, "full_drain1");
        expect_at(e + 27, SG_CYC, 0, "full_cyc0");
        expect_at(e + 30, SG_PHASE, 1, "full_fill2");
        expect_at(e + 30, SG_SEC, 2, "full_fill2_sec");
        expect_at(e + 33, SG_CYC, 1, "full_rinse_cyc");
        expect_at(e + 45, SG_PHASE, 6, "full_drain2");
        expect_at(e + 48, SG_PHASE, 7, "full_spin");
        expect_at(e + 48, SG_DRY, 1, "full_dry");
        expect_at(e + 48, SG_DRAIN, 1, "full_spin_drain");
        expect_at(e + 50, SG_DONE, 0, "full_not_done");
        expect_at(e + 51, SG_DONE, 1, "full_done");
        tick(1); start = 1'b0;
        wait_to(e + 52);

        // rinse with a 5-cycle pause inside AGIT_F
        launch(2'd1, e);
        expect_at(e + 4, SG_FWD, 0, "pause_fwd_off");
        expect_at(e + 7, SG_PHASE, 2, "pause_frozen_phase");
        expect_at(e + 7, SG_SEC, 2, "pause_frozen_sec");
        expect_at(e + 7, SG_FWD, 0, "pause_fwd_off2");
        expect_at(e + 9, SG_FWD, 1, "pause_resume_fwd");
        expect_at(e + 9, SG_SEC, 2, "pause_resume_sec");
        expect_at(e + 10, SG_SEC, 1, "pause_count_on");
        expect_at(e + 12, SG_PHASE, 3, "pause_pause_a");
        expect_at(e + 22, SG_PHASE, 6, "pause_drain");
        expect_at(e + 22, SG_DONE, 0, "pause_not_done");
        expect_at(e + 23, SG_DONE, 1, "pause_done");
        tick(1); start = 1'b0;
        wait_to(e + 4); pause = 1'b1;
        wait_to(e + 9); pause = 1'b0;
        wait_to(e + 24);

        // mode 0 in DONE holds, then estop clears DONE
        launch(2'd0, e);
        expect_at(e, SG_PHASE, 8, "mode0_done_phase");
        expect_at(e, SG_DONE, 1, "mode0_done_hold");
        tick(1); start = 1'b0;
        estop = 1'b1;
        expect_at(edge_n + 1, SG_PHASE, 0, "estop_done_phase");
        expect_at(edge_n + 1, SG_DONE, 0, "estop_done_clr");
        tick(1); estop = 1'b0;

        // spin-only aborted by estop during DRAIN
        launch(2'd3, e);
        expect_at(e, SG_PHASE, 6, "spin_drain");
        expect_at(e, SG_DRAIN, 1, "spin_drain_out");
        expect_at(e, SG_SEC, 2, "spin_drain_sec");
        expect_at(e + 1, SG_SEC, 1, "spin_drain_sec1");
        expect_at(e + 2, SG_PHASE, 0, "estop_phase");
        expect_at(e + 2, SG_DRAIN, 0, "estop_drain");
        expect_at(e + 2, SG_BUSY, 0, "estop_busy");
        expect_at(e + 2, SG_SEC, 0, "estop_sec");
        tick(1); start = 1'b0;
        wait_to(e + 1); estop = 1'b1;
        tick(1); estop = 1'b0;

        // clean restart of spin-only
        launch(2'd3, e);
        expect_at(e, SG_PHASE, 6, "respin_drain");
        expect_at(e + 3, SG_PHASE, 7, "respin_spin");
        expect_at(e + 3, SG_DRY, 1, "respin_dry");
        expect_at(e + 3, SG_SEC, 2, "respin_sec");
        expect_at(e + 6, SG_PHASE, 8, "respin_done_phase");
        expect_at(e + 6, SG_DRAIN, 0, "respin_done_drain");
        tick(1); start = 1'b0;
        wait_to(e + 6);

        // rst in SPIN aborts the run
        launch(2'd3, e);
        expect_at(e + 3, SG_PHASE, 7, "rst_run_spin");
        expect_at(e + 5, SG_PHASE, 0, "rst_mid_phase");
        expect_at(e + 5, SG_IDLE, 1, "rst_mid_led");
        expect_at(e + 5, SG_DRY, 0, "rst_mid_dry");
        expect_at(e + 5, SG_DRAIN, 0, "rst_mid_drain");
        expect_at(e + 5, SG_SEC, 0, "rst_mid_sec");
        expect_at(e + 7, SG_PHASE, 0, "rst_after_phase");
        expect_at(e + 7, SG_BUSY, 0, "rst_after_busy");
        tick(1); start = 1'b0;
        wait_to(e + 4); rst = 1'b1;
        tick(1); rst = 1'b0;
        wait_to(e + 7);

`ifdef WASHER_SEQ_LEVEL_EN
        auto_level = 1'b0; man_level = 1'b0;
        launch(2'd1, e);
        expect_at(e + 3, SG_PHASE, 9, "lvl_fault_phase");
        expect_at(e + 3, SG_FAULT, 1, "lvl_fault");
        expect_at(e + 3, SG_INLET, 0, "lvl_fault_inlet");
        expect_at(e + 5, SG_PHASE, 9, "lvl_fault_sticky");
        expect_at(e + 6, SG_FAULT, 0, "lvl_fault_estop");
        tick(1); start = 1'b0;
        wait_to(e + 4); mode_sel = 2'd1; start = 1'b1;
        tick(1); start = 1'b0; estop = 1'b1;
        tick(1); estop = 1'b0;
        launch(2'd1, e);
        expect_at(e + 1, SG_PHASE, 1, "lvl_still_fill");
        expect_at(e + 2, SG_PHASE, 2, "lvl_early_agit");
        expect_at(e + 2, SG_CYC, 1, "lvl_early_cyc");
        tick(1); start = 1'b0;
        wait_to(e + 1); man_level = 1'b1;
        wait_to(e + 3); man_level = 1'b0; estop = 1'b1;
        tick(1); estop = 1'b0;
`endif

        tick(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
